// File: rtl/word_pingpong_ctrl_if.sv
// word_pingpong_ctrl_if: parser byte stream in, word byte stream out, plus status.
interface word_pingpong_ctrl_if #(
    parameter int WORD_MAX_LEN = 32
);
    localparam int LEN_W = $clog2(WORD_MAX_LEN + 1);
    logic [7:0]       din;
    logic             din_valid;
    logic             din_last;
    logic             din_ready;
    logic [7:0]       dout;
    logic             dout_valid;
    logic             dout_last;
    logic             dout_ready;
    logic [LEN_W-1:0] word_len;
    logic [1:0]       words_pending;
    logic             err_overflow;
    modport master (
        output din, din_valid, din_last, dout_ready,
        input  din_ready, dout, dout_valid, dout_last, word_len, words_pending, err_overflow
    );
    modport slave (
        input  din, din_valid, din_last, dout_ready,
        output din_ready, dout, dout_valid, dout_last, word_len, words_pending, err_overflow
    );
endinterface

// File: rtl/word_pingpong_ctrl.sv
// word_pingpong_ctrl: two word buffers filled alternately from the parser and drained in arrival order.
module word_storage #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_set_full,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_set_empty,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata,
    output logic              o_full,
    output logic [LEN_W-1:0]  o_len
);
    logic [7:0]       r_mem [DEPTH];
    logic             r_full;
    logic [LEN_W-1:0] r_len;
    always_ff @(posedge CLK) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_full <= 1'b0;
            r_len  <= '0;
        end else if (i_set_full) begin
            r_full <= 1'b1;
            r_len  <= i_len;
        end else if (i_set_empty) begin
            r_full <= 1'b0;
        end
    end
    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;
    assign o_len   = r_len;
endmodule

module word_pingpong_ctrl #(
    parameter int WORD_MAX_LEN = 32
) (
    input logic                   CLK,
    input logic                   rst,
    word_pingpong_ctrl_if.slave   bus
);
    localparam int ADDR_W = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1;
    localparam int LEN_W  = $clog2(WORD_MAX_LEN + 1);
    typedef enum logic [1:0] {W_FILL, W_WAIT, W_DISCARD} w_state_t;
    w_state_t          r_state, w_state_nx;
    logic              r_wr_buf, w_wr_buf_nx;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nx;
    logic              r_err, w_err_nx;
    logic              r_rd_buf;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [1:0]        w_full, w_set_full, w_set_empty;
    logic [7:0]        w_rdata [2];
    logic [LEN_W-1:0]  w_len [2];
    logic [LEN_W-1:0]  w_wlen;
    logic              w_din_ready, w_acc, w_we, w_rd_last, w_rd_xfer;
    for (genvar b = 0; b < 2; b++) begin : g_buf
        word_storage #(.DEPTH(WORD_MAX_LEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_store (
            .CLK         (CLK),
            .rst         (rst),
            .i_we        (w_we & (r_wr_buf == 1'(b))),
            .i_waddr     (r_wr_addr),
            .i_wdata     (bus.din),
            .i_set_full  (w_set_full[b]),
            .i_len       (w_wlen),
            .i_set_empty (w_set_empty[b]),
            .i_raddr     (r_rd_addr),
            .o_rdata     (w_rdata[b]),
            .o_full      (w_full[b]),
            .o_len       (w_len[b])
        );
    end
    assign w_din_ready = (r_state == W_FILL) ? ~w_full[r_wr_buf] : (r_state == W_DISCARD);
    assign w_acc       = bus.din_valid & w_din_ready;
    assign w_wlen      = LEN_W'(r_wr_addr) + LEN_W'(1);
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= W_FILL;
            r_wr_buf  <= 1'b0;
            r_wr_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_wr_buf  <= w_wr_buf_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_err     <= w_err_nx;
        end
    end
    // A buffer being drained this cycle counts as free, so writing resumes one cycle after the last read.
    always_comb begin
        w_state_nx   = r_state;
        w_wr_buf_nx  = r_wr_buf;
        w_wr_addr_nx = r_wr_addr;
        w_err_nx     = r_err;
        w_we         = 1'b0;
        w_set_full   = '0;
        case (r_state)
            W_FILL: begin
                if (w_acc) begin
                    w_we = 1'b1;
                    if (bus.din_last) begin
                        w_set_full[r_wr_buf] = 1'b1;
                        w_wr_addr_nx         = '0;
                        w_wr_buf_nx          = ~r_wr_buf;
                        if (w_full[~r_wr_buf] & ~w_set_empty[~r_wr_buf]) w_state_nx = W_WAIT;
                    end else if (r_wr_addr == ADDR_W'(WORD_MAX_LEN - 1)) begin
                        w_err_nx     = 1'b1;
                        w_wr_addr_nx = '0;
                        w_state_nx   = W_DISCARD;
                    end else begin
                        w_wr_addr_nx = r_wr_addr + ADDR_W'(1);
                    end
                end
            end
            W_WAIT:    w_state_nx = (~w_full[r_wr_buf] | w_set_empty[r_wr_buf]) ? W_FILL : W_WAIT;
            W_DISCARD: w_state_nx = (w_acc & bus.din_last) ? W_FILL : W_DISCARD;
            default:   w_state_nx = W_FILL;
        endcase
    end
    assign w_rd_last   = w_full[r_rd_buf] & (LEN_W'(r_rd_addr) == w_len[r_rd_buf] - LEN_W'(1));
    assign w_rd_xfer   = w_full[r_rd_buf] & bus.dout_ready;
    assign w_set_empty = (w_rd_xfer & w_rd_last) ? (r_rd_buf ? 2'b10 : 2'b01) : 2'b00;
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_rd_buf  <= 1'b0;
            r_rd_addr <= '0;
        end else if (w_rd_xfer) begin
            r_rd_addr <= w_rd_last ? '0 : r_rd_addr + ADDR_W'(1);
            r_rd_buf  <= w_rd_last ? ~r_rd_buf : r_rd_buf;
        end
    end
    assign bus.din_ready     = w_din_ready;
    assign bus.dout          = w_rdata[r_rd_buf];
    assign bus.dout_valid    = w_full[r_rd_buf];
    assign bus.dout_last     = w_rd_last;
    assign bus.word_len      = w_full[r_rd_buf] ? w_len[r_rd_buf] : '0;
    assign bus.words_pending = {1'b0, w_full[0]} + {1'b0, w_full[1]};
    assign bus.err_overflow  = r_err;
endmodule
